serial_addsub_ctrl: RTL

Sequencer that reuses a single 1-bit full-adder slice to add or subtract two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It gives an area-minimal alternative to the ripple adder/subtractor. It sits between a requester using a START/DONE handshake and the one full-adder cell. It owns the operand shift registers, the carry flop and the bit counter.

---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/serial_addsub_ctrl_full_adder.sv | 20 ++
 rtl/serial_addsub_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared definitions for the bit-serial adder/subtractor sequencer:
// FSM state encoding, default operand width and the bit-counter width helper.
// No ports (package).

package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0 .. width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// full_adder
// One-bit full-adder cell used as the bit slice of the serial adder.
// Ports:
//   a, b  : input  operand bits
//   cin   : input  carry in
//   sum   : output sum bit
//   cout  : output carry out

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// Adds or subtracts two WIDTH-bit operands bit-serially, LSB first, one bit
// per clock, through a single full_adder slice. Requester handshake is
// start/done; the block owns the operand shift registers, carry flop and
// bit counter.
// Optional feature macro: SERIAL_ADDSUB_SAT_EN -- when defined, a signed
// overflow saturates result to the signed extreme selected by the MSB of a.
// Ports:
//   clk     : input  rising-edge clock
//   rst_n   : input  asynchronous active-low reset
//   start   : input  request, sampled in IDLE or DONE
//   sub     : input  0 = a+b, 1 = a-b, sampled with start
//   a, b    : input  WIDTH-bit operands, sampled with start
//   busy    : output high while running
//   done    : output one-cycle pulse, result/cout/ovf valid
//   result  : output WIDTH-bit sum/difference, held until the next done
//   cout    : output final carry out (sub: 1 = no borrow)
//   ovf     : output signed overflow

module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb;
  // Holds the sum bits produced so far; the newest bit enters at the top.
  logic [WIDTH-2:0] sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum_bit, slice_cout;
  logic             accept, last_bit, ovf_now;
  logic [WIDTH-1:0] final_sum, result_next;

  assign accept    = (state != RUN) && start;
  assign last_bit  = (state == RUN) && (cnt == LAST_BIT);
  assign final_sum = {sum_bit, sr};
  // Carry into the MSB is the carry flop during the last bit.
  assign ovf_now   = carry ^ slice_cout;

  full_adder u_slice (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (sum_bit),
    .cout (slice_cout)
  );

`ifdef SERIAL_ADDSUB_SAT_EN
  // Sign of a is lost from sa once shifting starts, so keep it aside.
  logic a_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      a_msb <= 1'b0;
    else if (accept) a_msb <= a[WIDTH-1];
  end

  assign result_next = !ovf_now ? final_sum :
                       a_msb    ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign result_next = final_sum;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they are true registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      sr    <= final_sum[WIDTH-1:1];
      carry <= slice_cout;
      cnt   <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (last_bit) begin
      result <= result_next;
      cout   <= slice_cout;
      ovf    <= ovf_now;
    end
  end

endmodule
